win_scanner: RTL and testbench

// - Parametrised, sequential connect-N win/draw detector for the board held in board_red/board_grn.
// - Snapshots both colour planes on token_ready, then scans one anchor cell per clock.
// - Reports game_over/winner with a one-cycle done pulse; busy is high while a scan is in progress.
// - Sits between the token-drop logic and the display/score logic.

---
 rtl/win_scanner.sv | 200 ++++++++++++++++++++
 tb/tb_win_scanner.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/win_scanner.sv
// win_scanner: sequential connect-N win/draw detector.
// Snapshots the playable columns of both colour planes on token_ready, then
// evaluates one anchor cell per clock in row-major order. A win ends the scan
// early; a full board with no win is a draw. game_over/winner are sticky.
// Optional feature macro: WIN_LINE_EN adds win_row/win_col/win_dir outputs
// reporting the anchor and direction of the winning line.
module win_scanner #(
  parameter int ROWS    = 6,
  parameter int COLS    = 7,
  parameter int COL_OFS = 9,
  parameter int BOARD_W = 16,
  parameter int CONNECT = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ROWS-1:0][BOARD_W-1:0]   board_red,
  input  logic [ROWS-1:0][BOARD_W-1:0]   board_grn,
  input  logic                           token_ready,
  output logic                           busy,
  output logic                           done,
  output logic                           game_over,
  output logic [1:0]                     winner
`ifdef WIN_LINE_EN
  , output logic [$clog2(ROWS)-1:0]      win_row
  , output logic [$clog2(COLS)-1:0]      win_col
  , output logic [1:0]                   win_dir
`endif
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int CELLS = ROWS * COLS;
  localparam int CNT_W = $clog2(CELLS + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  // Parameter sanity checks at elaboration.
  if (CONNECT < 2) begin : g_chk_connect_min
    $error("win_scanner: CONNECT must be >= 2");
  end
  if (CONNECT > ROWS) begin : g_chk_connect_rows
    $error("win_scanner: CONNECT must be <= ROWS");
  end
  if (CONNECT > COLS) begin : g_chk_connect_cols
    $error("win_scanner: CONNECT must be <= COLS");
  end
  if (COL_OFS + COLS > BOARD_W) begin : g_chk_cols_fit
    $error("win_scanner: COL_OFS+COLS must be <= BOARD_W");
  end

  typedef logic [ROWS-1:0][COLS-1:0] plane_t;

  logic [0:0]       state;
  logic             pending;
  plane_t           snap_red;
  plane_t           snap_grn;
  logic [RW-1:0]    row_idx;
  logic [CW-1:0]    col_idx;
  logic [CNT_W-1:0] fill_cnt;

  logic             cell_filled;
  logic [CNT_W-1:0] fill_next;
  logic             last_anchor;
  logic [3:0]       red_dirs;
  logic [3:0]       grn_dirs;
  logic             red_win;
  logic             grn_win;
  logic [3:0]       hit_dirs;
  logic [1:0]       hit_dir;

  // Only the playable columns are consumed; the remaining row-word bits are
  // folded here so they are visibly accounted for.
  logic unused_board_bits;
  assign unused_board_bits = ^{board_red, board_grn};

  // Keep only the playable columns of a board plane.
  function automatic plane_t extract(input logic [ROWS-1:0][BOARD_W-1:0] b);
    plane_t p;
    for (int r = 0; r < ROWS; r++) begin
      p[r] = b[r][COL_OFS +: COLS];
    end
    return p;
  endfunction

  // True when CONNECT cells from (r,c) in direction d are all set in p.
  // Any cell leaving the grid disqualifies the direction.
  function automatic logic line_hit(input plane_t p, input int r, input int c,
                                    input int d);
    logic hit;
    int   rr;
    int   cc;
    hit = 1'b1;
    for (int k = 0; k < CONNECT; k++) begin
      rr = r + ((d == 1 || d == 2) ? k : ((d == 3) ? -k : 0));
      cc = c + ((d == 1) ? 0 : k);
      if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
        hit = 1'b0;
      end else if (!p[rr[RW-1:0]][cc[CW-1:0]]) begin
        hit = 1'b0;
      end
    end
    return hit;
  endfunction

  assign busy        = (state == SCAN);
  assign cell_filled = snap_red[row_idx][col_idx] | snap_grn[row_idx][col_idx];
  assign fill_next   = fill_cnt + CNT_W'(cell_filled);
  assign last_anchor = (row_idx == RW'(ROWS - 1)) && (col_idx == CW'(COLS - 1));

  // Evaluate all directions at the current anchor and pick the reported line.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    red_dirs = '0;
    grn_dirs = '0;
    hit_dir  = '0;
    for (int d = 0; d < 4; d++) begin
      red_dirs[d] = line_hit(snap_red, int'(row_idx), int'(col_idx), d);
      grn_dirs[d] = line_hit(snap_grn, int'(row_idx), int'(col_idx), d);
    end
    red_win  = |red_dirs;
    grn_win  = |grn_dirs;
    hit_dirs = red_win ? red_dirs : grn_dirs;
    for (int d = 3; d >= 0; d--) begin
      if (hit_dirs[d]) hit_dir = 2'(d);
    end
  end

  // Scan FSM, snapshot capture, anchor walk and sticky result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state     <= IDLE;
      pending   <= 1'b0;
      // NOTE: the snapshot is small and must read as an empty board after reset, so it is reset too.
      snap_red  <= '0;
      snap_grn  <= '0;
      row_idx   <= '0;
      col_idx   <= '0;
      fill_cnt  <= '0;
      done      <= 1'b0;
      game_over <= 1'b0;
      winner    <= 2'b00;
`ifdef WIN_LINE_EN
      win_row   <= '0;
      win_col   <= '0;
      win_dir   <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (game_over) begin
            pending <= 1'b0;
          end else if (token_ready || pending) begin
            snap_red <= extract(board_red);
            snap_grn <= extract(board_grn);
            row_idx  <= '0;
            col_idx  <= '0;
            fill_cnt <= '0;
            pending  <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (token_ready) pending <= 1'b1;
          if (red_win || grn_win) begin
            game_over <= 1'b1;
            winner    <= red_win ? 2'b01 : 2'b10;
            done      <= 1'b1;
            state     <= IDLE;
`ifdef WIN_LINE_EN
            win_row   <= row_idx;
            win_col   <= col_idx;
            win_dir   <= hit_dir;
`endif
          end else if (last_anchor) begin
            done     <= 1'b1;
            state    <= IDLE;
            fill_cnt <= fill_next;
            if (fill_next == CNT_W'(CELLS)) begin
              game_over <= 1'b1;
              winner    <= 2'b11;
            end
          end else begin
            fill_cnt <= fill_next;
            if (col_idx == CW'(COLS - 1)) begin
              col_idx <= '0;
              row_idx <= row_idx + RW'(1);
            end else begin
              col_idx <= col_idx + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_win_scanner.sv
// Directed testbench for win_scanner at default parameters.
// Cycle T is the posedge that samples token_ready; the value "at T+n" is
// sampled on the falling edge following posedge T+n-1.
module tb_win_scanner;

  localparam int ROWS = 6;
  localparam int COLS = 7;
  localparam int OFS  = 9;
  localparam int BW   = 16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [ROWS-1:0][BW-1:0]  board_red;
  logic [ROWS-1:0][BW-1:0]  board_grn;
  logic                     token_ready;
  logic                     busy;
  logic                     done;
  logic                     game_over;
  logic [1:0]               winner;
`ifdef WIN_LINE_EN
  logic [2:0]               win_row;
  logic [2:0]               win_col;
  logic [1:0]               win_dir;
`endif

  int vecs = 0;
  int errs = 0;

  win_scanner dut (
    .clk         (clk),
    .reset       (reset),
    .board_red   (board_red),
    .board_grn   (board_grn),
    .token_ready (token_ready),
    .busy        (busy),
    .done        (done),
    .game_over   (game_over),
    .winner      (winner)
`ifdef WIN_LINE_EN
    , .win_row   (win_row)
    , .win_col   (win_col)
    , .win_dir   (win_dir)
`endif
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    token_ready = 1'b0;
    board_red   = '0;
    board_grn   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic put(input bit red, input int r, input int c);
    if (red) board_red[r][OFS + c] = 1'b1;
    else     board_grn[r][OFS + c] = 1'b1;
  endtask

  // Pulse token_ready, then count cycles until done (bounded).
  task automatic launch(output int lat, output logic busy1);
    @(negedge clk);
    token_ready = 1'b1;
    @(negedge clk);
    token_ready = 1'b0;
    lat   = 1;
    busy1 = busy;
    while (done !== 1'b1 && lat < 120) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", busy); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", done); end
    vecs++; if (game_over !== 1'b0) begin errs++; $display("FAIL reset_game_over: got %b want 0", game_over); end
    vecs++; if (winner !== 2'b00) begin errs++; $display("FAIL reset_winner: got %b want 00", winner); end
`ifdef WIN_LINE_EN
    vecs++; if ({win_row, win_col, win_dir} !== 8'h00) begin errs++; $display("FAIL reset_win_line: got %h want 00", {win_row, win_col, win_dir}); end
`endif
  endtask

  task automatic test_horizontal();
    int lat; logic b1;
    do_reset();
    for (int c = 0; c < 4; c++) put(1'b1, 5, c);
    launch(lat, b1);
    vecs++; if (b1 !== 1'b1) begin errs++; $display("FAIL horiz_busy_t1: got %b want 1", b1); end
    vecs++; if (lat !== 37) begin errs++; $display("FAIL horiz_latency: got %0d want 37", lat); end
    vecs++; if (winner !== 2'b01) begin errs++; $display("FAIL horiz_winner: got %b want 01", winner); end
    vecs++; if (game_over !== 1'b1) begin errs++; $display("FAIL horiz_game_over: got %b want 1", game_over); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL horiz_busy_at_done: got %b want 0", busy); end
`ifdef WIN_LINE_EN
    vecs++; if (win_row !== 3'd5 || win_col !== 3'd0 || win_dir !== 2'd0) begin errs++; $display("FAIL horiz_line: got r%0d c%0d d%0d want r5 c0 d0", win_row, win_col, win_dir); end
`endif
    @(negedge clk);
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL horiz_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_vertical();
    int lat; logic b1;
    do_reset();
    for (int r = 2; r < 6; r++) put(1'b0, r, 0);
    launch(lat, b1);
    vecs++; if (lat !== 16) begin errs++; $display("FAIL vert_latency: got %0d want 16", lat); end
    vecs++; if (winner !== 2'b10) begin errs++; $display("FAIL vert_winner: got %b want 10", winner); end
`ifdef WIN_LINE_EN
    vecs++; if (win_row !== 3'd2 || win_col !== 3'd0 || win_dir !== 2'd1) begin errs++; $display("FAIL vert_line: got r%0d c%0d d%0d want r2 c0 d1", win_row, win_col, win_dir); end
`endif
  endtask

  task automatic test_diag_up(input bit with_green);
    int lat; logic b1;
    do_reset();
    for (int k = 0; k < 4; k++) put(1'b1, 2 + k, k);
    if (with_green) for (int c = 0; c < 4; c++) put(1'b0, 2, c);
    launch(lat, b1);
    vecs++; if (lat !== 16) begin errs++; $display("FAIL diag_up%0d_latency: got %0d want 16", with_green, lat); end
    vecs++; if (winner !== 2'b01) begin errs++; $display("FAIL diag_up%0d_winner: got %b want 01", with_green, winner); end
`ifdef WIN_LINE_EN
    vecs++; if (win_dir !== 2'd2) begin errs++; $display("FAIL diag_up%0d_dir: got %0d want 2", with_green, win_dir); end
`endif
  endtask

  task automatic test_diag_down();
    int lat; logic b1;
    do_reset();
    for (int k = 0; k < 4; k++) put(1'b1, 5 - k, k);
    launch(lat, b1);
    vecs++; if (lat !== 37) begin errs++; $display("FAIL diag_down_latency: got %0d want 37", lat); end
    vecs++; if (winner !== 2'b01) begin errs++; $display("FAIL diag_down_winner: got %b want 01", winner); end
`ifdef WIN_LINE_EN
    vecs++; if (win_row !== 3'd5 || win_col !== 3'd0 || win_dir !== 2'd3) begin errs++; $display("FAIL diag_down_line: got r%0d c%0d d%0d want r5 c0 d3", win_row, win_col, win_dir); end
`endif
  endtask

  // Green line at anchor 0 beats a red line anchored later; afterwards
  // token_ready must be ignored while game_over holds.
  task automatic test_earliest_and_sticky();
    int lat; int extra; logic b1;
    do_reset();
    for (int c = 0; c < 4; c++) put(1'b0, 0, c);
    for (int r = 0; r < 4; r++) put(1'b1, r, 6);
    launch(lat, b1);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL earliest_latency: got %0d want 2", lat); end
    vecs++; if (winner !== 2'b10) begin errs++; $display("FAIL earliest_winner: got %b want 10", winner); end
    board_grn = '0;
    board_red = '1;
    @(negedge clk);
    token_ready = 1'b1;
    @(negedge clk);
    token_ready = 1'b0;
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      if (done === 1'b1 || busy === 1'b1) extra++;
      @(negedge clk);
    end
    vecs++; if (extra !== 0) begin errs++; $display("FAIL sticky_ignore: got %0d active cycles want 0", extra); end
    vecs++; if (winner !== 2'b10 || game_over !== 1'b1) begin errs++; $display("FAIL sticky_hold: got go=%b w=%b want go=1 w=10", game_over, winner); end
  endtask

  task automatic test_draw();
    int lat; logic b1;
    do_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        put(((r / 2) + c) % 2 == 0, r, c);
    launch(lat, b1);
    vecs++; if (lat !== 43) begin errs++; $display("FAIL draw_latency: got %0d want 43", lat); end
    vecs++; if (winner !== 2'b11) begin errs++; $display("FAIL draw_winner: got %b want 11", winner); end
    vecs++; if (game_over !== 1'b1) begin errs++; $display("FAIL draw_game_over: got %b want 1", game_over); end
`ifdef WIN_LINE_EN
    vecs++; if ({win_row, win_col, win_dir} !== 8'h00) begin errs++; $display("FAIL draw_win_line: got %h want 00", {win_row, win_col, win_dir}); end
`endif
  endtask

  // Non-playable bits set, a row-wrapping near-line, a vertical three, and the
  // live board turning all-red mid-scan: none of it may produce a result.
  task automatic test_empty_like();
    int lat;
    do_reset();
    for (int r = 0; r < ROWS; r++) begin
      board_red[r] = 16'h01FF;
      board_grn[r] = 16'h01FF;
    end
    put(1'b1, 0, 4); put(1'b1, 0, 5); put(1'b1, 0, 6); put(1'b1, 1, 0);
    for (int r = 0; r < 3; r++) put(1'b0, r, 2);
    @(negedge clk);
    token_ready = 1'b1;
    @(negedge clk);
    token_ready = 1'b0;
    board_red = '1;
    lat = 1;
    while (done !== 1'b1 && lat < 120) begin
      @(negedge clk);
      lat++;
    end
    vecs++; if (lat !== 43) begin errs++; $display("FAIL empty_latency: got %0d want 43", lat); end
    vecs++; if (winner !== 2'b00) begin errs++; $display("FAIL empty_winner: got %b want 00", winner); end
    vecs++; if (game_over !== 1'b0) begin errs++; $display("FAIL empty_game_over: got %b want 0", game_over); end
  endtask

  task automatic test_reset_mid_scan();
    int lat; int seen;
    do_reset();
    @(negedge clk);
    token_ready = 1'b1;
    @(negedge clk);
    token_ready = 1'b0;
    lat = 1;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
    end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    vecs++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL midreset_outputs: got busy=%b done=%b want 0 0", busy, done); end
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    vecs++; if (seen !== 0) begin errs++; $display("FAIL midreset_no_done: got %0d pulses want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat; int gap;
    do_reset();
    @(negedge clk);
    token_ready = 1'b1;
    @(negedge clk);
    token_ready = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 120) begin
      @(negedge clk);
      lat++;
      if (lat == 5) token_ready = 1'b1;
      if (lat == 6) token_ready = 1'b0;
    end
    vecs++; if (lat !== 43) begin errs++; $display("FAIL b2b_first_latency: got %0d want 43", lat); end
    @(negedge clk);
    gap = 1;
    vecs++; if (done !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL b2b_restart: got done=%b busy=%b want 0 1", done, busy); end
    while (done !== 1'b1 && gap < 120) begin
      @(negedge clk);
      gap++;
    end
    vecs++; if (gap !== 43) begin errs++; $display("FAIL b2b_gap: got %0d want 43", gap); end
    @(negedge clk);
    vecs++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL b2b_idle_after: got busy=%b done=%b want 0 0", busy, done); end
  endtask

  initial begin
    reset       = 1'b1;
    token_ready = 1'b0;
    board_red   = '0;
    board_grn   = '0;
    test_reset();
    test_horizontal();
    test_vertical();
    test_diag_up(1'b0);
    test_diag_up(1'b1);
    test_diag_down();
    test_earliest_and_sticky();
    test_draw();
    test_empty_like();
    test_reset_mid_scan();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
